// File: rtl/polyphase_interp_fir_if.sv
// Stream, control and tap-load signals of the polyphase interpolating FIR.
// The master side drives samples, taps and control; the slave side is the filter.
interface polyphase_interp_fir_if #(
    parameter int G_DWIDTH         = 24,
    parameter int G_TAP_WIDTH      = 16,
    parameter int G_TAPS_PER_PHASE = 16,
    parameter int G_MAX_RATE       = 8
) ();
    localparam int C_RSW = $clog2(G_MAX_RATE) + 1;
    localparam int C_AW  = $clog2(G_MAX_RATE * G_TAPS_PER_PHASE);

    logic                          enable;
    logic [C_RSW-1:0]              rate_sel;
    logic                          tap_wr_en;
    logic [C_AW-1:0]               tap_wr_addr;
    logic signed [G_TAP_WIDTH-1:0] tap_wr_data;
    logic signed [G_DWIDTH-1:0]    din;
    logic                          din_valid;
    logic                          din_ready;
    logic signed [G_DWIDTH-1:0]    dout;
    logic                          dout_valid;
    logic                          dout_ready;
    logic                          busy;
    logic                          sat_pulse;

    modport master (
        output enable, rate_sel, tap_wr_en, tap_wr_addr, tap_wr_data,
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, busy, sat_pulse
    );

    modport slave (
        input  enable, rate_sel, tap_wr_en, tap_wr_addr, tap_wr_data,
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, busy, sat_pulse
    );
endinterface

// File: rtl/polyphase_interp_fir.sv
// Runtime-rate polyphase interpolating FIR: one time-multiplexed MAC walks the
// T non-zero taps of each branch, emitting 2^rate outputs per accepted sample.
module polyphase_interp_fir #(
    parameter int G_DWIDTH         = 24,
    parameter int G_TAP_WIDTH      = 16,
    parameter int G_TAPS_PER_PHASE = 16,
    parameter int G_MAX_RATE       = 8,
    parameter int G_ACC_GUARD      = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    polyphase_interp_fir_if.slave  bus
);
    localparam int C_T     = G_TAPS_PER_PHASE;
    localparam int C_RL    = $clog2(G_MAX_RATE);
    localparam int C_RSW   = C_RL + 1;
    localparam int C_PW    = C_RL;
    localparam int C_AW    = $clog2(G_MAX_RATE * C_T);
    localparam int C_CW    = $clog2(C_T + 1);
    localparam int C_KW    = $clog2(C_T);
    localparam int C_PRODW = G_DWIDTH + G_TAP_WIDTH;
    localparam int C_ACCW  = G_DWIDTH + G_TAP_WIDTH + G_ACC_GUARD;

    localparam logic signed [C_ACCW-1:0] C_HALF =
        {{(C_ACCW-1){1'b0}}, 1'b1} << (G_TAP_WIDTH - 2);
    localparam logic signed [C_ACCW-1:0] C_MAXV =
        {{(C_ACCW-G_DWIDTH+1){1'b0}}, {(G_DWIDTH-1){1'b1}}};
    localparam logic signed [C_ACCW-1:0] C_MINV =
        {{(C_ACCW-G_DWIDTH+1){1'b1}}, {(G_DWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                        r_state;
    logic [C_PW-1:0]               r_phase;
    logic [C_RSW-1:0]              r_rate;
    logic [C_CW-1:0]               r_cnt;
    logic signed [G_DWIDTH-1:0]    r_x [C_T];
    logic signed [C_ACCW-1:0]      r_acc;
    logic                          r_din_ready;
    logic                          r_dout_valid;
    logic signed [G_DWIDTH-1:0]    r_dout;
    logic                          r_busy;
    logic                          r_sat_pulse;
    logic signed [G_TAP_WIDTH-1:0] r_taps [G_MAX_RATE * C_T];
    logic signed [G_TAP_WIDTH-1:0] r_tap_q;

    logic                          w_in_hs;
    logic [C_RSW-1:0]              w_rate_clamped;
    logic [C_PW-1:0]               w_phase_last;
    logic [C_CW-1:0]               w_rd_k;
    logic [C_AW-1:0]               w_rd_addr;
    logic [C_KW-1:0]               w_x_idx;
    logic signed [C_PRODW-1:0]     w_prod;
    logic signed [C_ACCW-1:0]      w_prod_ext;
    logic signed [C_ACCW-1:0]      w_acc_next;
    logic signed [C_ACCW-1:0]      w_rnd;
    logic signed [C_ACCW-1:0]      w_shift;
    logic signed [G_DWIDTH-1:0]    w_sat_dout;
    logic                          w_sat;

    assign w_in_hs        = bus.din_valid && r_din_ready;
    assign w_rate_clamped = (bus.rate_sel > C_RSW'(C_RL)) ? C_RSW'(C_RL) : bus.rate_sel;
    assign w_phase_last   = C_PW'((32'd1 << r_rate) - 32'd1);

    // The read for tap k is issued in MAC cycle k; its product lands in cycle k+1,
    // so the delay-line index trails the read counter by one.
    assign w_rd_k     = (r_cnt < C_CW'(C_T)) ? r_cnt : {C_CW{1'b0}};
    assign w_rd_addr  = C_AW'(int'(r_phase) * C_T + int'(w_rd_k));
    assign w_x_idx    = (r_cnt == {C_CW{1'b0}}) ? {C_KW{1'b0}} : C_KW'(r_cnt - C_CW'(1'b1));
    assign w_prod     = C_PRODW'(r_x[w_x_idx]) * C_PRODW'(r_tap_q);
    assign w_prod_ext = C_ACCW'(w_prod);

    // Accumulate, round half up, then clip to the output range.
    always_comb begin
        w_acc_next = r_acc + w_prod_ext;
        if (r_cnt == C_CW'(1'b1)) begin
            w_acc_next = w_prod_ext;
        end else begin
            w_acc_next = r_acc + w_prod_ext;
        end
        w_rnd   = w_acc_next + C_HALF;
        w_shift = w_rnd >>> (G_TAP_WIDTH - 1);
        if (w_shift > C_MAXV) begin
            w_sat_dout = C_MAXV[G_DWIDTH-1:0];
            w_sat      = 1'b1;
        end else if (w_shift < C_MINV) begin
            w_sat_dout = C_MINV[G_DWIDTH-1:0];
            w_sat      = 1'b1;
        end else begin
            w_sat_dout = w_shift[G_DWIDTH-1:0];
            w_sat      = 1'b0;
        end
    end

    // Tap RAM: writable only while the filter is disabled, one-cycle registered read.
    always_ff @(posedge clk) begin
        if (bus.tap_wr_en && !bus.enable) begin
            r_taps[bus.tap_wr_addr] <= bus.tap_wr_data;
        end
        r_tap_q <= r_taps[w_rd_addr];
    end

    // Control FSM, delay line, accumulator and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_phase      <= {C_PW{1'b0}};
            r_rate       <= {C_RSW{1'b0}};
            r_cnt        <= {C_CW{1'b0}};
            r_acc        <= {C_ACCW{1'b0}};
            r_din_ready  <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout       <= {G_DWIDTH{1'b0}};
            r_busy       <= 1'b0;
            r_sat_pulse  <= 1'b0;
            for (int i = 0; i < C_T; i++) begin
                r_x[i] <= {G_DWIDTH{1'b0}};
            end
        end else if (!bus.enable) begin
            // Disabled: abort any partial output and give the next run a clean history.
            r_state      <= S_IDLE;
            r_phase      <= {C_PW{1'b0}};
            r_rate       <= {C_RSW{1'b0}};
            r_cnt        <= {C_CW{1'b0}};
            r_acc        <= {C_ACCW{1'b0}};
            r_din_ready  <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout       <= {G_DWIDTH{1'b0}};
            r_busy       <= 1'b0;
            r_sat_pulse  <= 1'b0;
            for (int i = 0; i < C_T; i++) begin
                r_x[i] <= {G_DWIDTH{1'b0}};
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_hs) begin
                        for (int i = C_T - 1; i > 0; i--) begin
                            r_x[i] <= r_x[i-1];
                        end
                        r_x[0]      <= bus.din;
                        r_rate      <= w_rate_clamped;
                        r_phase     <= {C_PW{1'b0}};
                        r_cnt       <= {C_CW{1'b0}};
                        r_din_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_MAC;
                    end else begin
                        r_din_ready <= 1'b1;
                    end
                end
                S_MAC: begin
                    if (r_cnt != {C_CW{1'b0}}) begin
                        r_acc <= w_acc_next;
                    end
                    if (r_cnt == C_CW'(C_T)) begin
                        r_dout       <= w_sat_dout;
                        r_dout_valid <= 1'b1;
                        r_sat_pulse  <= w_sat;
                        r_state      <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt + C_CW'(1'b1);
                    end
                end
                S_OUT: begin
                    r_sat_pulse <= 1'b0;
                    if (bus.dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_cnt        <= {C_CW{1'b0}};
                        if (r_phase == w_phase_last) begin
                            r_busy      <= 1'b0;
                            r_din_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_phase <= r_phase + C_PW'(1'b1);
                            r_state <= S_MAC;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_din_ready  <= 1'b0;
                    r_dout_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_sat_pulse  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.din_ready  = r_din_ready;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.busy       = r_busy;
    assign bus.sat_pulse  = r_sat_pulse;
endmodule

// File: tb/tb_polyphase_interp_fir.sv
// Scoreboard bench for polyphase_interp_fir: a behavioural model queues the
// expected outputs per accepted sample; a monitor pops them on each output handshake.
module tb_polyphase_interp_fir;
    localparam int DW  = 24;
    localparam int TW  = 16;
    localparam int T   = 16;
    localparam int MR  = 8;
    localparam int RSW = 4;
    localparam int AW  = 7;

    typedef struct {
        longint val;
        bit     sat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    polyphase_interp_fir_if #(.G_DWIDTH(DW), .G_TAP_WIDTH(TW),
                              .G_TAPS_PER_PHASE(T), .G_MAX_RATE(MR)) bus ();

    polyphase_interp_fir #(.G_DWIDTH(DW), .G_TAP_WIDTH(TW), .G_TAPS_PER_PHASE(T),
                           .G_MAX_RATE(MR), .G_ACC_GUARD(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t                 exp_q[$];
    exp_t                 mon_e;
    int                   n_checks = 0;
    int                   n_errors = 0;
    int                   n_outs = 0;
    int                   out_log [1024];
    int                   rdy_mode = 0;
    int                   tb_rate = 0;
    bit                   prev_stall = 1'b0;
    logic signed [DW-1:0] held;
    logic signed [TW-1:0] mh [MR*T];
    logic signed [DW-1:0] mx [T];

    task automatic chk(input string tag, input longint got, input longint expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < T; i++) mx[i] = '0;
        exp_q.delete();
    endtask

    task automatic push_sample(input logic signed [DW-1:0] v);
        longint acc;
        longint y;
        int     rl;
        exp_t   e;
        for (int i = T - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = v;
        rl = (tb_rate > 3) ? 3 : tb_rate;
        for (int p = 0; p < (1 << rl); p++) begin
            acc = 0;
            for (int k = 0; k < T; k++) acc += longint'(mx[k]) * longint'(mh[p*T + k]);
            y = (acc + 64'sd16384) >>> 15;
            e.sat = 1'b0;
            if (y > 64'sd8388607) begin
                y = 64'sd8388607;
                e.sat = 1'b1;
            end else if (y < -64'sd8388608) begin
                y = -64'sd8388608;
                e.sat = 1'b1;
            end
            e.val = y;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic signed [DW-1:0] v);
        bit got;
        got = 1'b0;
        bus.din       = v;
        bus.rate_sel  = RSW'(tb_rate);
        bus.din_valid = 1'b1;
        for (int n = 0; n < 5000 && !got; n++) begin
            @(negedge clk);
            if (bus.din_ready) got = 1'b1;
        end
        chk("din_accept", longint'(got), 1);
        if (got) push_sample(v);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", longint'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic write_tap(input int a, input logic signed [TW-1:0] v);
        bus.tap_wr_en   = 1'b1;
        bus.tap_wr_addr = AW'(a);
        bus.tap_wr_data = v;
        @(posedge clk);
        #1;
        bus.tap_wr_en = 1'b0;
        if (!bus.enable) mh[a] = v;
    endtask

    task automatic set_enable(input bit b);
        bus.enable = b;
        if (!b) model_flush();
        @(posedge clk);
        #1;
    endtask

    // Output-ready pattern: always ready, random backpressure, or full stall.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       bus.dout_ready = 1'($urandom_range(0, 1));
            2:       bus.dout_ready = 1'b0;
            default: bus.dout_ready = 1'b1;
        endcase
    end

    // Monitor: stall stability, sat_pulse on the first valid cycle, scoreboard pop.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else if (bus.dout_valid) begin
            if (!prev_stall) begin
                chk("exp_pending", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("sat_pulse", longint'(bus.sat_pulse), longint'(exp_q[0].sat));
            end else begin
                chk("sat_hold", longint'(bus.sat_pulse), 0);
                chk("stall_stable", longint'(bus.dout), longint'(held));
            end
            held = bus.dout;
            if (bus.dout_ready && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("dout", longint'(bus.dout), mon_e.val);
                if (n_outs < 1024) out_log[n_outs] = int'(bus.dout);
                n_outs++;
            end
            prev_stall = !bus.dout_ready;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        bit  got;
        logic signed [DW-1:0] rv;
        bus.enable      = 1'b0;
        bus.rate_sel    = '0;
        bus.tap_wr_en   = 1'b0;
        bus.tap_wr_addr = '0;
        bus.tap_wr_data = '0;
        bus.din         = '0;
        bus.din_valid   = 1'b0;
        bus.dout_ready  = 1'b1;
        for (int a = 0; a < MR*T; a++) mh[a] = '0;
        model_flush();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_din_ready", longint'(bus.din_ready), 0);
        chk("rst_dout_valid", longint'(bus.dout_valid), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_dout", longint'(bus.dout), 0);
        chk("rst_sat", longint'(bus.sat_pulse), 0);
        reset_n = 1'b1;

        // Impulse response, R=4, taps h[a]=a+1.
        for (int a = 0; a < MR*T; a++) write_tap(a, TW'(a + 1));
        bus.enable = 1'b1;
        chk("ready_at_enable", longint'(bus.din_ready), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ready_after_enable", longint'(bus.din_ready), 1);
        tb_rate = 2;
        base = n_outs;
        send(24'sd4194304);
        for (int i = 0; i < 15; i++) send(24'sd0);
        drain();
        for (int p = 0; p < 4; p++) chk("impulse_phase", longint'(out_log[base + p]), 128 * (16 * p + 1));
        chk("impulse_count", longint'(n_outs - base), 64);

        // DC gain, R=8: each phase sums to 32767.
        set_enable(1'b0);
        for (int a = 0; a < MR*T; a++) write_tap(a, ((a % T) == 15) ? 16'sd2047 : 16'sd2048);
        set_enable(1'b1);
        tb_rate = 3;
        base = n_outs;
        for (int i = 0; i < 20; i++) send(24'sd1000);
        drain();
        chk("dc_count", longint'(n_outs - base), 160);
        chk("dc_last", longint'(out_log[n_outs - 1]), 1000);

        // Saturation at both rails.
        set_enable(1'b0);
        for (int a = 0; a < MR*T; a++) write_tap(a, 16'sd32767);
        set_enable(1'b1);
        tb_rate = 1;
        for (int i = 0; i < 4; i++) send(24'sd8388607);
        chk("sat_pos", longint'(out_log[n_outs - 1 < 0 ? 0 : n_outs - 1]) <= 8388607, 1);
        drain();
        chk("sat_pos_last", longint'(out_log[n_outs - 1]), 8388607);
        for (int i = 0; i < 12; i++) send(-24'sd8388608);
        drain();
        chk("sat_neg_last", longint'(out_log[n_outs - 1]), -8388608);

        // Random backpressure with rate changes at input boundaries (7 clamps to 8x).
        set_enable(1'b0);
        for (int a = 0; a < MR*T; a++) write_tap(a, TW'(int'($urandom_range(0, 16000)) - 8000));
        set_enable(1'b1);
        rdy_mode = 1;
        base = n_outs;
        tb_rate = 1;
        for (int i = 0; i < 6; i++) begin rv = DW'($urandom); send(rv); end
        tb_rate = 3;
        for (int i = 0; i < 4; i++) begin rv = DW'($urandom); send(rv); end
        tb_rate = 7;
        rv = DW'($urandom);
        send(rv);
        tb_rate = 0;
        for (int i = 0; i < 3; i++) begin rv = DW'($urandom); send(rv); end
        drain();
        rdy_mode = 0;
        chk("bp_count", longint'(n_outs - base), 55);

        // Abort mid-MAC, then tap writes with enable high (ignored) and low (applied).
        tb_rate = 0;
        send(24'sd12345);
        repeat (5) @(posedge clk);
        #1;
        base = n_outs;
        set_enable(1'b0);
        chk("abort_busy", longint'(bus.busy), 0);
        chk("abort_valid", longint'(bus.dout_valid), 0);
        set_enable(1'b1);
        for (int a = 0; a < T; a++) write_tap(a, 16'sd999);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_out", longint'(n_outs - base), 0);
        set_enable(1'b0);
        for (int a = 0; a < 4; a++) write_tap(a, TW'(100 * (a + 1)));
        set_enable(1'b1);
        base = n_outs;
        send(24'sd4194304);
        for (int i = 0; i < 15; i++) send(24'sd0);
        drain();
        chk("wr_applied_0", longint'(out_log[base]), 12800);
        chk("wr_applied_1", longint'(out_log[base + 1]), 25600);

        // Reset while an output is held by backpressure.
        rdy_mode = 2;
        send(24'sd500);
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (bus.dout_valid) got = 1'b1;
        end
        chk("out_reached", longint'(got), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", longint'(bus.dout_valid), 0);
        chk("rst_mid_busy", longint'(bus.busy), 0);
        model_flush();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ready_after_reset", longint'(bus.din_ready), 1);
        base = n_outs;
        send(24'sd4194304);
        drain();
        chk("post_reset_out", longint'(out_log[base]), 12800);

        chk("q_final", longint'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/polyphase_interp_fir.md
Name: polyphase_interp_fir

Overview:
- Runtime-rate polyphase interpolating FIR. Replaces the fixed zero-insert plus full-rate FIR cascades in tulip_dsp upsampling paths.
- For each accepted input sample it produces R output samples, R = 2^rate_sel (1..G_MAX_RATE).
- One time-multiplexed MAC computes only the non-zero products of each polyphase branch.
- Taps are loaded at runtime through a write port, so one instance serves 1x/2x/4x/8x audio paths.

Parameters:
- G_DWIDTH, 24, signed sample width in and out.
- G_TAP_WIDTH, 16, signed tap width, Q1.(G_TAP_WIDTH-1).
- G_TAPS_PER_PHASE, 16, taps per polyphase branch (T); also the delay-line depth; >=2.
- G_MAX_RATE, 8, maximum interpolation factor; power of two, >=2.
- G_ACC_GUARD, 8, accumulator guard bits; accumulator width = G_DWIDTH+G_TAP_WIDTH+G_ACC_GUARD.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- enable, in, 1, synchronous run enable; 0 = flush/hold-off.
- rate_sel, in, $clog2(G_MAX_RATE)+1, log2 of interpolation factor; values above log2(G_MAX_RATE) clamp to G_MAX_RATE.
- tap_wr_en, in, 1, tap write strobe.
- tap_wr_addr, in, $clog2(G_MAX_RATE*G_TAPS_PER_PHASE), tap address = phase*T + k.
- tap_wr_data, in, G_TAP_WIDTH, signed tap value.
- din, in, G_DWIDTH, signed input sample.
- din_valid, in, 1, input valid.
- din_ready, out, 1, input ready.
- dout, out, G_DWIDTH, signed output sample.
- dout_valid, out, 1, output valid.
- dout_ready, in, 1, output ready.
- busy, out, 1, high whenever the FSM is not in IDLE.
- sat_pulse, out, 1, one-cycle pulse when the current output saturated.

Behaviour:
- Reset (reset_n=0, async): FSM=IDLE, phase=0, delay line cleared to 0, accumulator=0, din_ready=0, dout_valid=0, dout=0, busy=0, sat_pulse=0.
- Tap RAM is not reset; its contents are undefined until written.
- enable=0 (sync): same clears as reset except the tap RAM. Tap writes are accepted only while enable=0; tap_wr_en is ignored while enable=1.
- Tap RAM: G_MAX_RATE*T entries, 1-cycle registered read. Phase p of rate R uses addresses p*T .. p*T+T-1 for p<R. Software loads the bank matching the intended rate.
- Delay line: x[0] = newest sample, x[T-1] = oldest. Shifts only on an input handshake.
- Input handshake (din_valid && din_ready): din shifts into x[0]; rate_sel is sampled into R_reg; phase=0. rate_sel changes take effect only at input boundaries.
- FSM:
  - IDLE: din_ready=1 (when enable=1). On input handshake -> MAC.
  - MAC: issues T tap reads k=0..T-1 on consecutive cycles. Accumulates x[k]*h[phase*T+k] one cycle after each read. Accumulator is cleared on the first product. Takes T+1 cycles, then -> OUT.
  - OUT: dout_valid=1, dout held stable until dout_ready.
    - On output handshake with phase==R_reg-1 -> IDLE.
    - Otherwise phase++ -> MAC.
- Latency: input handshake at cycle 0 -> first dout_valid at cycle T+2. Each subsequent phase's dout_valid arrives T+2 cycles after the previous output handshake.
- din_ready is high the cycle after the last output handshake.
- Arithmetic:
  - Products are full precision, accumulated in G_DWIDTH+G_TAP_WIDTH+G_ACC_GUARD bits.
  - Result = (acc + 2^(G_TAP_WIDTH-2)) >>> (G_TAP_WIDTH-1), i.e. round half up.
  - The result saturates to [-2^(G_DWIDTH-1), 2^(G_DWIDTH-1)-1].
  - sat_pulse is asserted for the single cycle dout_valid first rises on a clipped output.
- Interpolation gain R is carried in the taps (each phase has DC gain 1.0). No post-shift is applied.
- Backpressure: dout_ready low holds OUT indefinitely. No state other than the held output changes during the stall.
- R=1: one output per input, plain FIR of T taps using bank 0.
- enable dropping mid-MAC or mid-OUT: the FSM aborts the partial output with no dout_valid. The delay line is zeroed, so the first sample after re-enable sees a clean history.
- Simultaneous din_valid and enable rising: the sample is not accepted in the cycle enable rises. din_ready first asserts the following cycle.

Test Plan:
- Reset/idle: reset_n=0 mid-OUT -> dout_valid=0, busy=0 immediately.
  - After release with enable=1, din_ready=1 on the second clk edge.
- Impulse, R=4, T=16, taps h[a]=a+1 (a=0..63): din=2^22 then zeros -> outputs on the first input are 2^22*(p*16+1)>>>15 rounded, i.e. 128*(16p+1) for p=0..3.
  - Outputs on subsequent inputs walk k=1..15 of each phase.
- DC gain: taps give each phase sum=32767, R=8, din constant 1000 -> after 16 inputs every output = 1000 (±1), 8 outputs per input.
- Saturation: all taps 32767, din=2^23-1 -> dout=2^23-1, with one sat_pulse per output.
  - Negative full scale -> dout=-2^23.
- Backpressure/rate switch: dout_ready toggled randomly; rate_sel changed 1->3 mid-burst.
  - Output count per input follows the rate latched at each input.
  - dout stays stable while stalled; no sample is dropped or duplicated versus the golden model.
- enable drop mid-MAC, tap writes with enable=1 and enable=0:
  - Aborted output is not emitted; history is zeroed.
  - Writes are ignored while enable=1 and applied while enable=0, confirmed by an impulse response.
